// File: rtl/scan_port.sv
// Inbound character device: the host pushes bytes into a FIFO, the core drains them via DATA reads.
// Optional build macro SCAN_PORT_IRQ_EN adds a registered "data available" irq output.
module scan_port #(
   parameter int buffer_depth = 16,
   parameter int count_width  = $clog2(buffer_depth) + 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        host_valid,
   input  logic [7:0]  host_data,
   output logic        host_full,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready
`ifdef SCAN_PORT_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int ptr_width = $clog2(buffer_depth);
   localparam logic [count_width-1:0] depth_c     = count_width'(buffer_depth);
   localparam logic [count_width-1:0] count_one_c = count_width'(1);
   localparam logic [ptr_width-1:0]   ptr_one_c   = ptr_width'(1);

   localparam logic [1:0] reg_data_c   = 2'd0;
   localparam logic [1:0] reg_status_c = 2'd1;

   logic [7:0]             fifo_r [buffer_depth];
   logic [ptr_width-1:0]   wr_ptr_r, rd_ptr_r;
   logic [ptr_width-1:0]   wr_ptr_next_s, rd_ptr_next_s;
   logic [count_width-1:0] count_r, count_next_s;
   logic                   overflow_r, overflow_next_s;
   logic                   host_full_r;
   logic                   mem_ready_r;
   logic [31:0]            mem_rdata_r, rdata_next_s;

   logic                   is_write_s, full_s, empty_s;
   logic                   pop_s, push_s, drop_s, flush_s, clr_ovf_s;
   logic                   irq_bit_s;
   logic                   unused_s;

   // Instruction fetches behave like data accesses; only addr[3:2] and wdata bits 0/17 matter.
   assign unused_s = ^{mem_instr, mem_addr[31:4], mem_addr[1:0],
                       mem_wdata[31:18], mem_wdata[16:1]};

`ifdef SCAN_PORT_IRQ_EN
   logic irq_r;
   assign irq_bit_s = irq_r;
   assign irq       = irq_r;
`else
   assign irq_bit_s = 1'b0;
`endif

   assign host_full = host_full_r;
   assign mem_ready = mem_ready_r;
   assign mem_rdata = mem_rdata_r;

   // Request decode, push/pop arbitration and next-state computation.
   always_comb begin
      is_write_s      = 1'b0;
      full_s          = 1'b0;
      empty_s         = 1'b0;
      pop_s           = 1'b0;
      flush_s         = 1'b0;
      clr_ovf_s       = 1'b0;
      push_s          = 1'b0;
      drop_s          = 1'b0;
      rdata_next_s    = 32'd0;
      wr_ptr_next_s   = wr_ptr_r;
      rd_ptr_next_s   = rd_ptr_r;
      count_next_s    = count_r;
      overflow_next_s = overflow_r;

      is_write_s = (mem_wstrb != 4'd0);
      full_s     = (count_r == depth_c);
      empty_s    = (count_r == {count_width{1'b0}});

      if (mem_valid) begin
         case (mem_addr[3:2])
            reg_data_c: begin
               if (!is_write_s && !empty_s) begin
                  pop_s        = 1'b1;
                  rdata_next_s = {23'd0, 1'b1, fifo_r[rd_ptr_r]};
               end else begin
                  rdata_next_s = 32'd0;
               end
            end
            reg_status_c: begin
               if (is_write_s) begin
                  flush_s   = mem_wdata[0];
                  clr_ovf_s = mem_wdata[17];
               end else begin
                  rdata_next_s = {13'd0, irq_bit_s, overflow_r, full_s, 16'(count_r)};
               end
            end
            default: begin
               rdata_next_s = 32'd0;
            end
         endcase
      end else begin
         rdata_next_s = 32'd0;
      end

      // Fullness is judged on the start-of-cycle count; a flush swallows any push outright.
      if (host_valid && !flush_s) begin
         push_s = !full_s;
         drop_s = full_s;
      end else begin
         push_s = 1'b0;
         drop_s = 1'b0;
      end

      if (flush_s) begin
         wr_ptr_next_s = {ptr_width{1'b0}};
         rd_ptr_next_s = {ptr_width{1'b0}};
         count_next_s  = {count_width{1'b0}};
      end else begin
         wr_ptr_next_s = push_s ? wr_ptr_r + ptr_one_c : wr_ptr_r;
         rd_ptr_next_s = pop_s  ? rd_ptr_r + ptr_one_c : rd_ptr_r;
         if (push_s && !pop_s) begin
            count_next_s = count_r + count_one_c;
         end else if (pop_s && !push_s) begin
            count_next_s = count_r - count_one_c;
         end else begin
            count_next_s = count_r;
         end
      end

      overflow_next_s = (overflow_r && !clr_ovf_s) || drop_s;
   end

   // FIFO storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge clock) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= host_data;
      end
   end

   // Pointer, occupancy, status and bus response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r    <= {ptr_width{1'b0}};
         rd_ptr_r    <= {ptr_width{1'b0}};
         count_r     <= {count_width{1'b0}};
         overflow_r  <= 1'b0;
         host_full_r <= 1'b0;
         mem_ready_r <= 1'b0;
         mem_rdata_r <= 32'd0;
      end else begin
         wr_ptr_r    <= wr_ptr_next_s;
         rd_ptr_r    <= rd_ptr_next_s;
         count_r     <= count_next_s;
         overflow_r  <= overflow_next_s;
         host_full_r <= (count_next_s == depth_c);
         mem_ready_r <= mem_valid;
         mem_rdata_r <= rdata_next_s;
      end
   end

`ifdef SCAN_PORT_IRQ_EN
   // Data-available interrupt, tracking the updated occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= (count_next_s != {count_width{1'b0}});
      end
   end
`endif

endmodule

// File: tb/tb_scan_port.sv
// Scoreboard bench for scan_port: stimulus queues expected read data, a negedge monitor checks responses.
module tb_scan_port;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        host_valid = 1'b0;
   logic [7:0]  host_data = 8'd0;
   logic        host_full;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
`ifdef SCAN_PORT_IRQ_EN
   logic        irq;
`endif

   int compared_cnt = 0;
   int mismatch_cnt = 0;
   bit mon_en = 1'b0;
   logic [31:0] exp_q [$];

   scan_port #(.buffer_depth(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .host_valid (host_valid),
      .host_data  (host_data),
      .host_full  (host_full),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
`ifdef SCAN_PORT_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared_cnt++;
      if (act !== exp) begin
         mismatch_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] status_exp(input bit ovf, input int cnt);
      logic [31:0] v;
      v        = 32'd0;
      v[15:0]  = cnt[15:0];
      v[16]    = (cnt == 16);
      v[17]    = ovf;
`ifdef SCAN_PORT_IRQ_EN
      v[18]    = (cnt != 0);
`endif
      return v;
   endfunction

   // One bus request; host_valid/host_data set by the caller are sampled on the same edge.
   task automatic bus(input logic [1:0] reg_idx, input logic [3:0] wstrb,
                      input logic [31:0] wdata, input logic [31:0] exp);
      mem_valid = 1'b1;
      mem_addr  = 32'h0100_0000 + {28'd0, reg_idx, 2'b00};
      mem_wstrb = wstrb;
      mem_wdata = wdata;
      exp_q.push_back(exp);
      @(posedge clock);
      #1;
      mem_valid  = 1'b0;
      mem_wstrb  = 4'd0;
      mem_wdata  = 32'd0;
      host_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      host_valid = 1'b1;
      host_data  = b;
      @(posedge clock);
      #1;
      host_valid = 1'b0;
   endtask

   // Response monitor: every mem_ready pops one expectation; idle cycles must show rdata 0.
   always @(negedge clock) begin
      if (mon_en) begin
         if (mem_ready) begin
            if (exp_q.size() == 0) begin
               compared_cnt++;
               mismatch_cnt++;
               $display("FAIL unexpected_resp: got rdata 0x%08h expected no response", mem_rdata);
            end else begin
               check("rdata", mem_rdata, exp_q.pop_front());
            end
         end else begin
            check("idle_rdata", mem_rdata, 32'd0);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Reset state
      check("reset_host_full", {31'd0, host_full}, 32'd0);
      bus(2'd1, 4'd0, 32'd0, 32'h0000_0000);

      // FIFO ordering
      push(8'h41); push(8'h42); push(8'h43);
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0141);
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0142);
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0143);
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0000);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b0, 0));
      bus(2'd2, 4'd0, 32'd0, 32'h0000_0000);
      bus(2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000);

      // Full and overflow, then drain with pointer wrap
      for (int i = 0; i < 17; i++) push(8'(i));
      check("full_after_fill", {31'd0, host_full}, 32'd1);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b1, 16));
      bus(2'd1, 4'hF, 32'h0002_0000, 32'h0000_0000);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b0, 16));
      bus(2'd0, 4'hF, 32'h0000_0001, 32'h0000_0000);
      for (int i = 0; i < 16; i++) bus(2'd0, 4'd0, 32'd0, 32'h0000_0100 | 32'(i));
      check("not_full_after_drain", {31'd0, host_full}, 32'd0);

      // Full FIFO: push 0x55 together with a DATA pop -> byte dropped, overflow set
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
      host_valid = 1'b1;
      host_data  = 8'h55;
      bus(2'd0, 4'd0, 32'd0, 32'h0000_01A0);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b1, 15));
      for (int i = 1; i < 16; i++) bus(2'd0, 4'd0, 32'd0, 32'h0000_01A0 + 32'(i));
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0000);
      bus(2'd1, 4'h1, 32'h0002_0000, 32'h0000_0000);

      // Empty FIFO: push together with a DATA read
      host_valid = 1'b1;
      host_data  = 8'h66;
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0000);
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0166);

      // Flush wins over a simultaneous push
      for (int i = 1; i <= 5; i++) push(8'(i));
      host_valid = 1'b1;
      host_data  = 8'h99;
      bus(2'd1, 4'h1, 32'h0000_0001, 32'h0000_0000);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b0, 0));
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0000);

      // Interrupt follows occupancy
`ifdef SCAN_PORT_IRQ_EN
      check("irq_idle", {31'd0, irq}, 32'd0);
`endif
      push(8'h7A);
`ifdef SCAN_PORT_IRQ_EN
      check("irq_rise", {31'd0, irq}, 32'd1);
`endif
      bus(2'd0, 4'd0, 32'd0, 32'h0000_017A);
`ifdef SCAN_PORT_IRQ_EN
      check("irq_fall", {31'd0, irq}, 32'd0);
`endif

      // Reset during traffic discards contents and the pending response
      push(8'h11); push(8'h22);
      mem_valid = 1'b1;
      mem_addr  = 32'h0100_0000;
      mem_wstrb = 4'd0;
      reset     = 1'b1;
      @(posedge clock);
      #1;
      mem_valid = 1'b0;
      reset     = 1'b0;
      check("reset_host_full2", {31'd0, host_full}, 32'd0);
      bus(2'd1, 4'd0, 32'd0, status_exp(1'b0, 0));
      bus(2'd0, 4'd0, 32'd0, 32'h0000_0000);

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
      repeat (2) @(posedge clock);
      check("pending_resp", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
      $finish;
   end

endmodule

// File: doc/scan_port.md
Name: scan_port

Overview:
- Memory-mapped character-input device for the simulation testbench. It is the inbound counterpart of the print device: the print device takes bytes written by the core, and this block delivers host-supplied bytes to the core.
- The testbench host pushes bytes into an internal FIFO. The core drains the FIFO by reading a data register over the core memory interface.
- Placed in the address window 0x1000004..0x1000010, just above the print device. The window is decoded externally, so `mem_valid` arrives already selected.

Parameters:
- `buffer_depth`, 16, FIFO entries. Must be a power of 2 and ≥2.
- `count_width`, `$clog2(buffer_depth)+1`, width of the occupancy counter.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `host_valid`  in  1  push strobe. One byte is offered per cycle while high.
- `host_data`  in  8  byte to push.
- `host_full`  out  1  FIFO full, registered. Equals `count == buffer_depth`.
- `mem_valid`  in  1  bus request. One request per cycle with `mem_valid=1`.
- `mem_instr`  in  1  instruction fetch flag. Treated the same as a data access.
- `mem_addr`  in  32  byte address. Only `[3:2]` is decoded.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte strobes. A value of 0 means a read.
- `mem_rdata`  out  32  read data, valid when `mem_ready=1`.
- `mem_ready`  out  1  response strobe.
- `irq`  out  1  only present with the optional feature.

Behaviour:
- Reset:
  - Clears read/write pointers, `count`, `overflow`, `mem_ready`, `mem_rdata` and `irq`.
  - `host_full` is 0 after reset.
  - A reset during traffic discards FIFO contents, and any response due in the next cycle is suppressed.
- Bus timing:
  - A request sampled at cycle N produces `mem_ready=1` at cycle N+1 for exactly one cycle, with `mem_rdata`.
  - Back-to-back requests are supported (throughput 1 per cycle).
  - `mem_rdata` is 0 on write responses and when `mem_ready=0`.
- Register map, selected by `mem_addr[3:2]`:
  - 0 DATA, read:
    - Non-empty: returns `{23'b0, 1'b1, head_byte}` (bit 8 = valid) and pops one entry.
    - Empty: returns 0 and does not pop.
    - Writes are ignored but still acknowledged.
  - 1 STATUS, read: returns `{14'b0, overflow, full, count zero-extended to 16b}`.
  - 1 STATUS, write (any `wstrb != 0`):
    - `wdata[0]=1` flushes the FIFO (pointers and `count` to 0).
    - `wdata[17]=1` clears `overflow`.
    - Both may be set together.
  - 2, 3: read 0, writes ignored, always acknowledged.
- Push rules:
  - `host_valid && count < buffer_depth` writes `host_data` at the write pointer and increments it.
  - `host_valid` while full drops the byte and sets sticky `overflow`.
- Simultaneous events:
  - Fullness uses the start-of-cycle `count`. A push arriving while full is dropped even if a DATA pop happens in the same cycle. Resulting `count` is `depth-1`, `overflow=1`.
  - Push into an empty FIFO in the same cycle as a DATA read: the read returns 0 and the pushed byte is stored (`count=1`).
  - Push with a non-full FIFO in the same cycle as a pop: `count` is unchanged and both pointers advance.
  - Flush and push in the same cycle: flush wins, the byte is dropped, and `overflow` is not set.
- Pointers wrap modulo `buffer_depth` (natural rollover of a `log2` pointer).
- `count` ranges 0..`buffer_depth`.

Optional Feature:
- Macro `SCAN_PORT_IRQ_EN`.
- Defined:
  - Adds output `irq`, registered, equal to `count != 0` computed on the updated `count`.
  - `irq` rises one cycle after the first push into an empty FIFO and falls one cycle after the pop or flush that empties it.
  - STATUS bit 18 reads `irq`.
- Undefined: no `irq` port, and STATUS bit 18 reads 0.

Test Plan:
- Reset check: after reset, read STATUS → `mem_ready` at N+1 with `rdata = 0x00000000`; `host_full=0`.
- FIFO ordering: push 0x41, 0x42, 0x43, then read DATA three times → `0x141`, `0x142`, `0x143`. A fourth read → `0x0`; STATUS `count=0`.
- Full and overflow: push 17 bytes (0x00..0x10) with depth 16 → `host_full=1`, STATUS = `0x00030010`. Write STATUS `0x00020000` → STATUS = `0x00010010`. Then 16 DATA reads → bytes 0x00..0x0F, in order, with wrap.
- Boundary same-cycle events:
  - Full FIFO, push 0x55 plus DATA read in the same cycle → `count=15`, `overflow=1`, and 0x55 is never read back.
  - Empty FIFO, push plus read in the same cycle → read returns 0, then the next read returns the pushed byte.
- Flush with push: push 5 bytes, then write STATUS `0x1` while pushing 0x99 in the same cycle → STATUS `count=0`, `overflow=0`, and a DATA read returns 0.
- IRQ (`SCAN_PORT_IRQ_EN`): push 0x7A → `irq` goes 1 on the next cycle. Read DATA → `irq` is 0 the cycle after the pop is performed.
